// File: rtl/apple2_mem_seq.sv
// Sequences CPU and video accesses onto one shared 17-bit external RAM port.
// Decodes CPU regions: I/O, ROM reads and unmapped card writes finish without a memory cycle.
module apple2_mem_seq (
    input  logic        mclk28,
    input  logic        reset_in,
    input  logic        cpu_strobe,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] ram_addr,
    input  logic        aux,
    input  logic        we,
    input  logic [7:0]  cpu_din,
    input  logic        card_ram_we,
    input  logic        card_ram_rd,
    input  logic        video_strobe,
    input  logic [16:0] video_addr,
    output logic        mem_req,
    output logic [16:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  cpu_dout,
    output logic        cpu_done,
    output logic        cpu_rom,
    output logic [7:0]  video_dout,
    output logic        video_done,
    output logic        overrun_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU_ACC,
        ST_VID_ACC,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic        pend;
        logic [16:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } cpu_slot_t;

    typedef struct packed {
        logic        pend;
        logic [16:0] addr;
    } vid_slot_t;

    state_t      state_q, state_d;
    cpu_slot_t   cslot_q, cslot_d;
    vid_slot_t   vslot_q, vslot_d;

    logic        mem_req_q, mem_req_d;
    logic [16:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [7:0]  cpu_dout_q, cpu_dout_d;
    logic [7:0]  video_dout_q, video_dout_d;
    logic        cpu_done_q, cpu_done_d;
    logic        video_done_q, video_done_d;
    logic        cpu_rom_q, cpu_rom_d;
    logic        overrun_q, overrun_d;

    logic        reg_io, reg_hi;
    logic        cpu_needs_ram, cpu_is_rom;
    logic        cpu_accept, vid_accept;
    logic        strobe_drop;

    // Region decode on the untranslated CPU address.
    always_comb begin
        reg_io        = (cpu_addr >= 16'hC000) && (cpu_addr < 16'hD000);
        reg_hi        = (cpu_addr >= 16'hD000);
        cpu_is_rom    = reg_hi && !we && !card_ram_rd;
        cpu_needs_ram = 1'b1;
        if (reg_io) begin
            cpu_needs_ram = 1'b0;
        end else if (reg_hi) begin
            cpu_needs_ram = we ? card_ram_we : card_ram_rd;
        end
    end

    // A slot stays busy until its ack edge, so a strobe in the ack cycle is dropped.
    assign cpu_accept  = cpu_strobe && !cslot_q.pend;
    assign vid_accept  = video_strobe && !vslot_q.pend;
    assign strobe_drop = (cpu_strobe && cslot_q.pend) || (video_strobe && vslot_q.pend);

    always_comb begin
        state_d      = state_q;
        cslot_d      = cslot_q;
        vslot_d      = vslot_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_dout_d   = cpu_dout_q;
        video_dout_d = video_dout_q;
        cpu_done_d   = 1'b0;
        video_done_d = 1'b0;
        cpu_rom_d    = cpu_rom_q;
        overrun_d    = overrun_q | strobe_drop;

        case (state_q)
            ST_IDLE: begin
                if (vslot_q.pend) begin
                    state_d     = ST_VID_ACC;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = vslot_q.addr;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = 8'h00;
                end else if (cslot_q.pend) begin
                    state_d     = ST_CPU_ACC;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = cslot_q.addr;
                    mem_we_d    = cslot_q.we;
                    mem_wdata_d = cslot_q.wdata;
                end
            end
            ST_CPU_ACC: begin
                if (mem_ack) begin
                    state_d      = ST_GAP;
                    mem_req_d    = 1'b0;
                    cslot_d.pend = 1'b0;
                    cpu_done_d   = 1'b1;
                    if (!cslot_q.we) begin
                        cpu_dout_d = mem_rdata;
                    end
                end
            end
            ST_VID_ACC: begin
                if (mem_ack) begin
                    state_d      = ST_GAP;
                    mem_req_d    = 1'b0;
                    vslot_d.pend = 1'b0;
                    video_done_d = 1'b1;
                    video_dout_d = mem_rdata;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // Accesses without a memory cycle complete here and never touch the FSM.
        if (cpu_accept) begin
            cpu_rom_d = cpu_is_rom;
            if (cpu_needs_ram) begin
                cslot_d.pend  = 1'b1;
                cslot_d.addr  = {aux, ram_addr};
                cslot_d.we    = we;
                cslot_d.wdata = cpu_din;
            end else begin
                cpu_done_d = 1'b1;
            end
        end

        if (vid_accept) begin
            vslot_d.pend = 1'b1;
            vslot_d.addr = video_addr;
        end
    end

    always_ff @(posedge mclk28) begin
        if (reset_in) begin
            state_q      <= ST_IDLE;
            cslot_q      <= '0;
            vslot_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            cpu_dout_q   <= '0;
            video_dout_q <= '0;
            cpu_done_q   <= 1'b0;
            video_done_q <= 1'b0;
            cpu_rom_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cslot_q      <= cslot_d;
            vslot_q      <= vslot_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_dout_q   <= cpu_dout_d;
            video_dout_q <= video_dout_d;
            cpu_done_q   <= cpu_done_d;
            video_done_q <= video_done_d;
            cpu_rom_q    <= cpu_rom_d;
            overrun_q    <= overrun_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign cpu_dout    = cpu_dout_q;
    assign video_dout  = video_dout_q;
    assign cpu_done    = cpu_done_q;
    assign video_done  = video_done_q;
    assign cpu_rom     = cpu_rom_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_apple2_mem_seq.sv
// Directed bench for apple2_mem_seq: a transaction-level model checked every cycle,
// a programmable-latency RAM responder and literal expectations per scenario.
module tb_apple2_mem_seq;

    logic        mclk28 = 1'b0;
    logic        reset_in = 1'b1;
    logic        cpu_strobe = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] ram_addr = '0;
    logic        aux = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  cpu_din = '0;
    logic        card_ram_we = 1'b0;
    logic        card_ram_rd = 1'b0;
    logic        video_strobe = 1'b0;
    logic [16:0] video_addr = '0;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  cpu_dout;
    logic        cpu_done;
    logic        cpu_rom;
    logic [7:0]  video_dout;
    logic        video_done;
    logic        overrun_err;

    apple2_mem_seq dut (
        .mclk28(mclk28), .reset_in(reset_in), .cpu_strobe(cpu_strobe), .cpu_addr(cpu_addr),
        .ram_addr(ram_addr), .aux(aux), .we(we), .cpu_din(cpu_din),
        .card_ram_we(card_ram_we), .card_ram_rd(card_ram_rd), .video_strobe(video_strobe),
        .video_addr(video_addr), .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .cpu_dout(cpu_dout),
        .cpu_done(cpu_done), .cpu_rom(cpu_rom), .video_dout(video_dout),
        .video_done(video_done), .overrun_err(overrun_err)
    );

    always #5 mclk28 = ~mclk28;

    // RAM responder: acks ack_dly cycles after it first sees mem_req high.
    int         ack_dly = 1;
    logic [7:0] ack_data = '0;
    logic       force_ack = 1'b0;
    int         rcnt = 0;
    always @(posedge mclk28) begin
        #2;
        if (mem_req) rcnt = rcnt + 1;
        else         rcnt = 0;
        mem_ack   = force_ack || (mem_req && (rcnt == ack_dly + 1));
        mem_rdata = ack_data;
    end

    // Transaction model: a port owner, a quiet-cycle cooldown and two request slots.
    logic        e_req, e_we, e_cdone, e_vdone, e_rom, e_ovr;
    logic [16:0] e_addr;
    logic [7:0]  e_wd, e_cdout, e_vdout;
    logic        p_cpu, p_vid, s_cwe, opc, opv, need_ram;
    logic [16:0] s_caddr, s_vaddr;
    logic [7:0]  s_cwd;
    int          owner, cool;
    always @(posedge mclk28) begin
        if (reset_in) begin
            e_req = 0; e_we = 0; e_cdone = 0; e_vdone = 0; e_rom = 0; e_ovr = 0;
            e_addr = 0; e_wd = 0; e_cdout = 0; e_vdout = 0;
            p_cpu = 0; p_vid = 0; s_cwe = 0; s_caddr = 0; s_vaddr = 0; s_cwd = 0;
            owner = 0; cool = 0;
        end else begin
            opc = p_cpu; opv = p_vid;
            e_cdone = 0; e_vdone = 0;
            if (owner != 0) begin
                if (mem_ack) begin
                    if (owner == 1) begin
                        if (!s_cwe) e_cdout = mem_rdata;
                        e_cdone = 1; p_cpu = 0;
                    end else begin
                        e_vdout = mem_rdata; e_vdone = 1; p_vid = 0;
                    end
                    owner = 0; e_req = 0; cool = 1;
                end
            end else if (cool > 0) begin
                cool = cool - 1;
            end else if (opv) begin
                owner = 2; e_req = 1; e_addr = s_vaddr; e_we = 0; e_wd = 0;
            end else if (opc) begin
                owner = 1; e_req = 1; e_addr = s_caddr; e_we = s_cwe; e_wd = s_cwd;
            end
            if (cpu_strobe) begin
                if (opc) e_ovr = 1;
                else begin
                    if (cpu_addr < 16'hC000)      need_ram = 1;
                    else if (cpu_addr < 16'hD000) need_ram = 0;
                    else                          need_ram = we ? card_ram_we : card_ram_rd;
                    e_rom = (cpu_addr >= 16'hD000) && !we && !card_ram_rd;
                    if (need_ram) begin
                        p_cpu = 1; s_caddr = {aux, ram_addr}; s_cwe = we; s_cwd = cpu_din;
                    end else e_cdone = 1;
                end
            end
            if (video_strobe) begin
                if (opv) e_ovr = 1;
                else begin p_vid = 1; s_vaddr = video_addr; end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk28);
        #1;
    endtask

    task automatic cpu_go(input logic [15:0] ca, input logic [15:0] ra, input logic ax,
                          input logic w, input logic [7:0] d, input logic crw, input logic crr);
        cpu_addr = ca; ram_addr = ra; aux = ax; we = w; cpu_din = d;
        card_ram_we = crw; card_ram_rd = crr; cpu_strobe = 1'b1;
        tick();
        cpu_strobe = 1'b0;
    endtask

    initial begin
        int n, nc, nv, cyc, gap, phase, bad;
        logic [16:0] addr2;

        reset_in = 1'b1;
        tick(); tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_cpu_dout", 32'(cpu_dout), 32'd0);
        chk("rst_video_dout", 32'(video_dout), 32'd0);
        chk("rst_dones", 32'({cpu_done, video_done}), 32'd0);
        chk("rst_rom_ovr", 32'({cpu_rom, overrun_err}), 32'd0);
        reset_in = 1'b0;

        fork
            forever begin
                @(negedge mclk28);
                chk("m_mem_req", 32'(mem_req), 32'(e_req));
                if (e_req) begin
                    chk("m_mem_addr", 32'(mem_addr), 32'(e_addr));
                    chk("m_mem_we", 32'(mem_we), 32'(e_we));
                    if (e_we) chk("m_mem_wdata", 32'(mem_wdata), 32'(e_wd));
                end
                chk("m_cpu_done", 32'(cpu_done), 32'(e_cdone));
                chk("m_video_done", 32'(video_done), 32'(e_vdone));
                chk("m_cpu_dout", 32'(cpu_dout), 32'(e_cdout));
                chk("m_video_dout", 32'(video_dout), 32'(e_vdout));
                chk("m_cpu_rom", 32'(cpu_rom), 32'(e_rom));
                chk("m_overrun", 32'(overrun_err), 32'(e_ovr));
            end
        join_none
        tick();

        // Aux CPU read, ack two cycles after mem_req rises.
        ack_dly = 2; ack_data = 8'h5A;
        cpu_go(16'h0400, 16'h0400, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("s1_req_lag", 32'(mem_req), 32'd0);
        tick();
        chk("s1_req_rise", 32'(mem_req), 32'd1);
        chk("s1_addr", 32'(mem_addr), 32'h10400);
        chk("s1_we", 32'(mem_we), 32'd0);
        n = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (cpu_done) n++; end
        chk("s1_done_cnt", 32'(n), 32'd1);
        chk("s1_dout", 32'(cpu_dout), 32'h5A);

        // Minimum latency: immediate ack gives done three cycles after the strobe.
        ack_dly = 0; ack_data = 8'hA5;
        cpu_go(16'h0123, 16'h0123, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc = 1;
        while (!cpu_done && cyc < 10) begin tick(); cyc++; end
        chk("lat_cycles", 32'(cyc), 32'd3);
        chk("lat_dout", 32'(cpu_dout), 32'hA5);
        tick(); tick(); tick();

        // ROM read, then card-RAM read in the same region.
        ack_dly = 1; ack_data = 8'h11;
        cpu_go(16'hD123, 16'hD123, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("s2_rom_done", 32'(cpu_done), 32'd1);
        chk("s2_rom_flag", 32'(cpu_rom), 32'd1);
        chk("s2_rom_noreq", 32'(mem_req), 32'd0);
        tick();
        chk("s2_rom_noreq2", 32'(mem_req), 32'd0);
        cpu_go(16'hD123, 16'hC123, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("s2_card_rom", 32'(cpu_rom), 32'd0);
        tick();
        chk("s2_card_addr", 32'(mem_addr), 32'h0C123);
        for (int i = 0; i < 6; i++) tick();
        chk("s2_card_dout", 32'(cpu_dout), 32'h11);

        // Card writes: suppressed without card_ram_we, issued with it.
        cpu_go(16'hE000, 16'hE000, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        chk("s3_sup_done", 32'(cpu_done), 32'd1);
        chk("s3_sup_noreq", 32'(mem_req), 32'd0);
        tick();
        chk("s3_sup_noreq2", 32'(mem_req), 32'd0);
        cpu_go(16'hE000, 16'hE000, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
        tick();
        chk("s3_wr_req", 32'(mem_req), 32'd1);
        chk("s3_wr_we", 32'(mem_we), 32'd1);
        chk("s3_wr_data", 32'(mem_wdata), 32'h77);
        chk("s3_wr_addr", 32'(mem_addr), 32'h0E000);
        for (int i = 0; i < 6; i++) tick();
        chk("s3_dout_kept", 32'(cpu_dout), 32'h11);

        // Simultaneous strobes: video first, two quiet cycles, then CPU.
        ack_data = 8'h3C;
        cpu_addr = 16'h0800; ram_addr = 16'h0800; aux = 1'b0; we = 1'b0;
        card_ram_we = 1'b0; card_ram_rd = 1'b0; video_addr = 17'h12000;
        cpu_strobe = 1'b1; video_strobe = 1'b1;
        tick();
        cpu_strobe = 1'b0; video_strobe = 1'b0;
        tick();
        chk("s4_first_addr", 32'(mem_addr), 32'h12000);
        chk("s4_first_we", 32'(mem_we), 32'd0);
        nv = 0; nc = 0; gap = 0; phase = 0; addr2 = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (video_done) nv++;
            if (cpu_done) nc++;
            if (phase == 0 && !mem_req) begin phase = 1; gap = 1; end
            else if (phase == 1) begin
                if (mem_req) begin phase = 2; addr2 = mem_addr; end
                else gap++;
            end
        end
        chk("s4_gap", 32'(gap), 32'd2);
        chk("s4_second_addr", 32'(addr2), 32'h00800);
        chk("s4_vdone_cnt", 32'(nv), 32'd1);
        chk("s4_cdone_cnt", 32'(nc), 32'd1);
        chk("s4_vdout", 32'(video_dout), 32'h3C);

        // Second CPU strobe while the first is waiting for ack gets dropped.
        ack_dly = 5;
        cpu_go(16'h1000, 16'h1000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        cpu_go(16'h2000, 16'h2000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("s5_ovr_set", 32'(overrun_err), 32'd1);
        bad = 0; n = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (mem_req && mem_addr == 17'h02000) bad++;
            if (cpu_done) n++;
        end
        chk("s5_no_drop_req", 32'(bad), 32'd0);
        chk("s5_done_cnt", 32'(n), 32'd1);
        chk("s5_ovr_sticky", 32'(overrun_err), 32'd1);

        // Reset in the middle of an access, followed by a stray ack.
        ack_dly = 30;
        cpu_go(16'h3000, 16'h3000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("s6_req_up", 32'(mem_req), 32'd1);
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        chk("s6_req_down", 32'(mem_req), 32'd0);
        chk("s6_addr_rst", 32'(mem_addr), 32'd0);
        chk("s6_cdout_rst", 32'(cpu_dout), 32'd0);
        chk("s6_vdout_rst", 32'(video_dout), 32'd0);
        chk("s6_ovr_rst", 32'(overrun_err), 32'd0);
        chk("s6_rom_rst", 32'(cpu_rom), 32'd0);
        force_ack = 1'b1; ack_data = 8'hEE;
        tick();
        force_ack = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (cpu_done || video_done) n++; end
        chk("s6_late_ack_done", 32'(n), 32'd0);
        chk("s6_late_ack_dout", 32'(cpu_dout), 32'd0);
        chk("s6_late_ack_req", 32'(mem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
